matrix_mem_arbiter: RTL and testbench
=====================================

Name: matrix_mem_arbiter

Overview:
- Shares the single-port matrix storage (slots A, B, C, scratch) between two requesters: the top-level FSM user port (UART load and result readback) and matrix_alu.
- Handles requester arbitration, slot/row/col-to-address translation, request registration and read-data return tagging.
- Sits between top/matrix_alu and the storage RAM, which has a 1-cycle synchronous read.

Parameters:
DATA_W, 16, element width (two's complement)
MAX_DIM, 5, maximum rows/cols per matrix; slot stride = MAX_DIM*MAX_DIM
NUM_SLOTS, 4, slots: 0=A, 1=B, 2=C, 3=scratch
SLOT_W, 2, slot index width
IDX_W, 3, row/col index width
ADDR_W, 7, RAM address width; must satisfy NUM_SLOTS*MAX_DIM*MAX_DIM <= 2^ADDR_W

Ports:
sys_clk_in  in  1  clock
sys_rst_n  in  1  asynchronous active-low reset
usr_req  in  1  user request; held with fields until usr_gnt
usr_we  in  1  1=write, 0=read
usr_slot  in  SLOT_W  slot index
usr_row  in  IDX_W  row index
usr_col  in  IDX_W  column index
usr_wdata  in  DATA_W  write data
usr_gnt  out  1  user request accepted this cycle (combinational)
usr_rd_valid  out  1  user read data valid
usr_rd_data  out  DATA_W  user read data
alu_req, alu_we, alu_slot, alu_row, alu_col, alu_wdata  in  (same widths as usr_*)  ALU request fields
alu_gnt  out  1  ALU request accepted
alu_rd_valid  out  1  ALU read data valid
alu_rd_data  out  DATA_W  ALU read data
mem_en  out  1  RAM access strobe
mem_we  out  1  RAM write enable
mem_addr  out  ADDR_W  RAM address
mem_wdata  out  DATA_W  RAM write data
mem_rdata  in  DATA_W  RAM read data, valid 1 cycle after mem_en with mem_we=0
arb_err  out  1  sticky out-of-range flag (optional feature only; tied 0 otherwise)

Behaviour:
- Transfer rule: a request transfers on a rising edge where req and gnt are both high. At most one gnt is high per cycle.
- Grant logic (combinational):
  - Only one requester active -> it is granted.
  - Both active -> round-robin by last_owner register: grant the requester that was not last granted.
- last_owner updates on every transfer. Reset value is ALU, so the user wins the first conflict.
- Address: mem_addr = slot*MAX_DIM*MAX_DIM + row*MAX_DIM + col, computed at ADDR_W+2 bits internally and truncated to ADDR_W.
- Pipeline timing, with T = transfer cycle:
  - T+1: mem_en=1, with mem_we/mem_addr/mem_wdata registered from the winner.
  - Read data return in T+2: the owner's rd_valid=1 and rd_data=mem_rdata.
  - A 2-stage owner/read tag pipeline tracks the in-flight accesses.
- Throughput: back-to-back transfers every cycle are allowed. Reads and writes may interleave freely; RAM order = grant order.
- Write-then-read to the same address on consecutive grants returns the new data (RAM is write-first).
- When not valid, rd_data outputs hold 0.
- Reset values: all gnt/rd_valid/mem_* outputs = 0, rd_data = 0, last_owner = ALU, tag pipeline cleared, arb_err = 0.
- Reset mid-operation: in-flight reads are discarded and no rd_valid is produced after reset release.
- Requester deasserting req without gnt: legal; nothing is issued.
- Simultaneous user and ALU requests to the same address: serialized by round-robin; no merging.

Optional Feature:
- Macro: MATRIX_MEM_ARB_BOUNDS_CHECK_EN.
- Enabled: a transfer with row >= MAX_DIM, col >= MAX_DIM or slot >= NUM_SLOTS is still granted, but:
  - mem_en stays 0 in T+1.
  - A read still returns rd_valid in T+2 with rd_data = 0.
  - arb_err sets and stays set until reset.
- Disabled: no checking; the truncated address is issued; arb_err tied 0.

Test Plan:
- User-only write slot 0 (row 1, col 2, data 16'h0014), then read same location -> write: mem_addr=7, mem_we=1 at T+1; read: usr_rd_valid at T+2 with usr_rd_data=16'h0014, alu_rd_valid stays 0.
- Both requesting reads every cycle for 6 cycles after reset -> grants alternate user, ALU, user, ALU, user, ALU; each rd_valid lands exactly 2 cycles after its gnt on the correct side.
- ALU writes C[1][1]=-30 (16'hFFE2), user reads C[1][1] next cycle -> mem_addr=56 for both; usr_rd_data=16'hFFE2.
- Reset asserted in the cycle after a user read is granted -> no usr_rd_valid ever; all outputs 0 during reset; first post-reset conflict grants user.
- With MATRIX_MEM_ARB_BOUNDS_CHECK_EN, user reads row 5, col 0 -> mem_en stays 0, usr_rd_valid with data 0 at T+2, arb_err=1 and sticky; without the macro, mem_addr=25 is issued and arb_err stays 0.

Source files
------------

// File: rtl/matrix_mem_arbiter.sv
// matrix_mem_arbiter
// Shares the single-port matrix RAM (slots A, B, C, scratch) between the
// user port and matrix_alu. It arbitrates round-robin, translates
// slot/row/col into a RAM address, and registers the winning request into
// the RAM stage. Read data is tagged with the requester and returned
// two cycles after the transfer.
// Optional feature: define MATRIX_MEM_ARB_BOUNDS_CHECK_EN to suppress
// out-of-range accesses, return zero for them, and raise a sticky arb_err.
module matrix_mem_arbiter #(
    parameter int DATA_W    = 16,
    parameter int MAX_DIM   = 5,
    parameter int NUM_SLOTS = 4,
    parameter int SLOT_W    = 2,
    parameter int IDX_W     = 3,
    parameter int ADDR_W    = 7
) (
    input  logic              sys_clk_in,
    input  logic              sys_rst_n,
    input  logic              usr_req,
    input  logic              usr_we,
    input  logic [SLOT_W-1:0] usr_slot,
    input  logic [IDX_W-1:0]  usr_row,
    input  logic [IDX_W-1:0]  usr_col,
    input  logic [DATA_W-1:0] usr_wdata,
    output logic              usr_gnt,
    output logic              usr_rd_valid,
    output logic [DATA_W-1:0] usr_rd_data,
    input  logic              alu_req,
    input  logic              alu_we,
    input  logic [SLOT_W-1:0] alu_slot,
    input  logic [IDX_W-1:0]  alu_row,
    input  logic [IDX_W-1:0]  alu_col,
    input  logic [DATA_W-1:0] alu_wdata,
    output logic              alu_gnt,
    output logic              alu_rd_valid,
    output logic [DATA_W-1:0] alu_rd_data,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              arb_err
);

    // Address arithmetic is carried two bits wider than the RAM address so
    // the sum cannot wrap before the final truncation.
    localparam int AW2 = ADDR_W + 2;

    localparam logic OWNER_USR = 1'b0;
    localparam logic OWNER_ALU = 1'b1;

    // Linear RAM address of a matrix element, truncated to ADDR_W bits.
    function automatic logic [ADDR_W-1:0] calc_addr(
        input logic [SLOT_W-1:0] slot,
        input logic [IDX_W-1:0]  row,
        input logic [IDX_W-1:0]  col
    );
        return ADDR_W'(AW2'(slot) * AW2'(MAX_DIM * MAX_DIM)
                     + AW2'(row) * AW2'(MAX_DIM)
                     + AW2'(col));
    endfunction

`ifdef MATRIX_MEM_ARB_BOUNDS_CHECK_EN
    // True when any coordinate lies outside the matrix store.
    function automatic logic out_of_range(
        input logic [SLOT_W-1:0] slot,
        input logic [IDX_W-1:0]  row,
        input logic [IDX_W-1:0]  col
    );
        return (int'(row) >= MAX_DIM) || (int'(col) >= MAX_DIM)
            || (int'(slot) >= NUM_SLOTS);
    endfunction
`endif

    logic              last_owner_r;
    logic              usr_gnt_s;
    logic              alu_gnt_s;
    logic              xfer_s;
    logic              win_owner_s;
    logic              win_we_s;
    logic [SLOT_W-1:0] win_slot_s;
    logic [IDX_W-1:0]  win_row_s;
    logic [IDX_W-1:0]  win_col_s;
    logic [DATA_W-1:0] win_wdata_s;
    logic [ADDR_W-1:0] win_addr_s;
    logic              oob_s;

    logic              mem_en_r;
    logic              mem_we_r;
    logic [ADDR_W-1:0] mem_addr_r;
    logic [DATA_W-1:0] mem_wdata_r;
    logic              s1_rd_r;
    logic              s1_owner_r;
    logic              s1_zero_r;

    logic              usr_rd_valid_r;
    logic              alu_rd_valid_r;
    logic              s2_zero_r;
    logic [DATA_W-1:0] usr_rd_data_s;
    logic [DATA_W-1:0] alu_rd_data_s;

    // Grant decision: a lone requester wins; on conflict the side not
    // granted last time wins. Nothing is granted while reset is asserted.
    always_comb begin
        usr_gnt_s = 1'b0;
        alu_gnt_s = 1'b0;
        if (!sys_rst_n) begin
            usr_gnt_s = 1'b0;
            alu_gnt_s = 1'b0;
        end else begin
            case ({usr_req, alu_req})
                2'b10: usr_gnt_s = 1'b1;
                2'b01: alu_gnt_s = 1'b1;
                2'b11: begin
                    if (last_owner_r == OWNER_ALU) begin
                        usr_gnt_s = 1'b1;
                    end else begin
                        alu_gnt_s = 1'b1;
                    end
                end
                default: begin
                    usr_gnt_s = 1'b0;
                    alu_gnt_s = 1'b0;
                end
            endcase
        end
    end

    // Select the fields of the granted requester.
    always_comb begin
        xfer_s      = usr_gnt_s | alu_gnt_s;
        win_owner_s = OWNER_USR;
        win_we_s    = 1'b0;
        win_slot_s  = {SLOT_W{1'b0}};
        win_row_s   = {IDX_W{1'b0}};
        win_col_s   = {IDX_W{1'b0}};
        win_wdata_s = {DATA_W{1'b0}};
        if (usr_gnt_s) begin
            win_owner_s = OWNER_USR;
            win_we_s    = usr_we;
            win_slot_s  = usr_slot;
            win_row_s   = usr_row;
            win_col_s   = usr_col;
            win_wdata_s = usr_wdata;
        end else if (alu_gnt_s) begin
            win_owner_s = OWNER_ALU;
            win_we_s    = alu_we;
            win_slot_s  = alu_slot;
            win_row_s   = alu_row;
            win_col_s   = alu_col;
            win_wdata_s = alu_wdata;
        end else begin
            win_owner_s = OWNER_USR;
        end
    end

    // Translate the winner's coordinates into a RAM address.
    always_comb begin
        win_addr_s = calc_addr(win_slot_s, win_row_s, win_col_s);
    end

`ifdef MATRIX_MEM_ARB_BOUNDS_CHECK_EN
    assign oob_s = xfer_s & out_of_range(win_slot_s, win_row_s, win_col_s);
`else
    assign oob_s = 1'b0;
`endif

    // Request stage: register the winner into the RAM strobe and start the
    // owner/read tag pipeline; remember who was granted for round-robin.
    always_ff @(posedge sys_clk_in or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            mem_en_r     <= 1'b0;
            mem_we_r     <= 1'b0;
            mem_addr_r   <= {ADDR_W{1'b0}};
            mem_wdata_r  <= {DATA_W{1'b0}};
            s1_rd_r      <= 1'b0;
            s1_owner_r   <= OWNER_USR;
            s1_zero_r    <= 1'b0;
            last_owner_r <= OWNER_ALU;
        end else begin
            mem_en_r   <= xfer_s & ~oob_s;
            mem_we_r   <= xfer_s & ~oob_s & win_we_s;
            if (xfer_s && !oob_s) begin
                mem_addr_r  <= win_addr_s;
                mem_wdata_r <= win_wdata_s;
            end else begin
                mem_addr_r  <= {ADDR_W{1'b0}};
                mem_wdata_r <= {DATA_W{1'b0}};
            end
            s1_rd_r    <= xfer_s & ~win_we_s;
            s1_owner_r <= win_owner_s;
            s1_zero_r  <= oob_s;
            if (xfer_s) begin
                last_owner_r <= win_owner_s;
            end else begin
                last_owner_r <= last_owner_r;
            end
        end
    end

    // Return stage: the RAM answers one cycle after the strobe, so the tag
    // is advanced once more to mark which side owns the returning data.
    always_ff @(posedge sys_clk_in or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            usr_rd_valid_r <= 1'b0;
            alu_rd_valid_r <= 1'b0;
            s2_zero_r      <= 1'b0;
        end else begin
            usr_rd_valid_r <= s1_rd_r & (s1_owner_r == OWNER_USR);
            alu_rd_valid_r <= s1_rd_r & (s1_owner_r == OWNER_ALU);
            s2_zero_r      <= s1_zero_r;
        end
    end

    // Route RAM data to the owning side; idle or suppressed reads show 0.
    always_comb begin
        usr_rd_data_s = {DATA_W{1'b0}};
        alu_rd_data_s = {DATA_W{1'b0}};
        if (usr_rd_valid_r && !s2_zero_r) begin
            usr_rd_data_s = mem_rdata;
        end else begin
            usr_rd_data_s = {DATA_W{1'b0}};
        end
        if (alu_rd_valid_r && !s2_zero_r) begin
            alu_rd_data_s = mem_rdata;
        end else begin
            alu_rd_data_s = {DATA_W{1'b0}};
        end
    end

`ifdef MATRIX_MEM_ARB_BOUNDS_CHECK_EN
    logic arb_err_r;

    // Sticky error flag: set by any out-of-range transfer, cleared only by reset.
    always_ff @(posedge sys_clk_in or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            arb_err_r <= 1'b0;
        end else if (oob_s) begin
            arb_err_r <= 1'b1;
        end else begin
            arb_err_r <= arb_err_r;
        end
    end

    assign arb_err = arb_err_r;
`else
    assign arb_err = 1'b0;
`endif

    assign usr_gnt      = usr_gnt_s;
    assign alu_gnt      = alu_gnt_s;
    assign mem_en       = mem_en_r;
    assign mem_we       = mem_we_r;
    assign mem_addr     = mem_addr_r;
    assign mem_wdata    = mem_wdata_r;
    assign usr_rd_valid = usr_rd_valid_r;
    assign alu_rd_valid = alu_rd_valid_r;
    assign usr_rd_data  = usr_rd_data_s;
    assign alu_rd_data  = alu_rd_data_s;

endmodule

// File: tb/tb_matrix_mem_arbiter.sv
// Testbench for matrix_mem_arbiter: a cycle-by-cycle vector table with
// hand-computed expectations, plus directed sequences for out-of-range
// access, reset during an in-flight read and post-reset round-robin.
// A small write-first RAM model with 1-cycle read latency drives mem_rdata.
module tb_matrix_mem_arbiter;

    logic        sys_clk_in;
    logic        sys_rst_n;
    logic        usr_req, usr_we;
    logic [1:0]  usr_slot;
    logic [2:0]  usr_row, usr_col;
    logic [15:0] usr_wdata;
    logic        usr_gnt, usr_rd_valid;
    logic [15:0] usr_rd_data;
    logic        alu_req, alu_we;
    logic [1:0]  alu_slot;
    logic [2:0]  alu_row, alu_col;
    logic [15:0] alu_wdata;
    logic        alu_gnt, alu_rd_valid;
    logic [15:0] alu_rd_data;
    logic        mem_en, mem_we;
    logic [6:0]  mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;
    logic        arb_err;

    logic        ram_clr;
    logic [15:0] ram [0:127];

    int checks = 0;
    int failures = 0;

    matrix_mem_arbiter dut (
        .sys_clk_in  (sys_clk_in),
        .sys_rst_n   (sys_rst_n),
        .usr_req     (usr_req),
        .usr_we      (usr_we),
        .usr_slot    (usr_slot),
        .usr_row     (usr_row),
        .usr_col     (usr_col),
        .usr_wdata   (usr_wdata),
        .usr_gnt     (usr_gnt),
        .usr_rd_valid(usr_rd_valid),
        .usr_rd_data (usr_rd_data),
        .alu_req     (alu_req),
        .alu_we      (alu_we),
        .alu_slot    (alu_slot),
        .alu_row     (alu_row),
        .alu_col     (alu_col),
        .alu_wdata   (alu_wdata),
        .alu_gnt     (alu_gnt),
        .alu_rd_valid(alu_rd_valid),
        .alu_rd_data (alu_rd_data),
        .mem_en      (mem_en),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata),
        .arb_err     (arb_err)
    );

    initial sys_clk_in = 1'b0;
    always #5 sys_clk_in = ~sys_clk_in;

    // RAM model: synchronous, write-first, one access per cycle.
    always @(posedge sys_clk_in) begin
        if (ram_clr) begin
            for (int i = 0; i < 128; i++) ram[i] <= 16'h0000;
            mem_rdata <= 16'h0000;
        end else if (mem_en) begin
            if (mem_we) ram[mem_addr] <= mem_wdata;
            else        mem_rdata <= ram[mem_addr];
        end
    end

    typedef struct packed {
        logic        ureq;
        logic        uwe;
        logic [1:0]  uslot;
        logic [2:0]  urow;
        logic [2:0]  ucol;
        logic [15:0] uwd;
        logic        areq;
        logic        awe;
        logic [1:0]  aslot;
        logic [2:0]  arow;
        logic [2:0]  acol;
        logic [15:0] awd;
        logic        e_ugnt;
        logic        e_agnt;
        logic        e_men;
        logic        e_mwe;
        logic [6:0]  e_maddr;
        logic [15:0] e_mwd;
        logic        e_urv;
        logic [15:0] e_urd;
        logic        e_arv;
        logic [15:0] e_ard;
    } vec_t;

    localparam int NV = 19;
    vec_t vecs [NV];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, " usr_gnt"},      32'(usr_gnt),      32'd0);
        chk({tag, " alu_gnt"},      32'(alu_gnt),      32'd0);
        chk({tag, " mem_en"},       32'(mem_en),       32'd0);
        chk({tag, " mem_we"},       32'(mem_we),       32'd0);
        chk({tag, " mem_addr"},     32'(mem_addr),     32'd0);
        chk({tag, " mem_wdata"},    32'(mem_wdata),    32'd0);
        chk({tag, " usr_rd_valid"}, 32'(usr_rd_valid), 32'd0);
        chk({tag, " usr_rd_data"},  32'(usr_rd_data),  32'd0);
        chk({tag, " alu_rd_valid"}, 32'(alu_rd_valid), 32'd0);
        chk({tag, " alu_rd_data"},  32'(alu_rd_data),  32'd0);
        chk({tag, " arb_err"},      32'(arb_err),      32'd0);
    endtask

    task automatic drive_idle();
        usr_req = 1'b0; usr_we = 1'b0; usr_slot = 2'd0; usr_row = 3'd0; usr_col = 3'd0; usr_wdata = 16'h0000;
        alu_req = 1'b0; alu_we = 1'b0; alu_slot = 2'd0; alu_row = 3'd0; alu_col = 3'd0; alu_wdata = 16'h0000;
    endtask

    logic exp_err;

    initial begin
        // User write A[1][2] (addr 7) then read it back; ALU writes C[1][1]
        // (addr 56) and user reads it; a 3-cycle conflict burst starting with
        // last_owner=USR; user writes scratch[4][4] (addr 99) while the ALU
        // requests and then withdraws; ALU reads addr 99 back.
        vecs[0]  = '{1'b1,1'b1,2'd0,3'd1,3'd2,16'h0014, 1'b0,1'b0,2'd0,3'd0,3'd0,16'h0000, 1'b1,1'b0,1'b0,1'b0,7'd0,16'h0000,  1'b0,16'h0000,1'b0,16'h0000};
        vecs[1]  = '{1'b1,1'b0,2'd0,3'd1,3'd2,16'h0000, 1'b0,1'b0,2'd0,3'd0,3'd0,16'h0000, 1'b1,1'b0,1'b1,1'b1,7'd7,16'h0014,  1'b0,16'h0000,1'b0,16'h0000};
        vecs[2]  = '{1'b0,1'b0,2'd0,3'd0,3'd0,16'h0000, 1'b0,1'b0,2'd0,3'd0,3'd0,16'h0000, 1'b0,1'b0,1'b1,1'b0,7'd7,16'h0000,  1'b0,16'h0000,1'b0,16'h0000};
        vecs[3]  = '{1'b0,1'b0,2'd0,3'd0,3'd0,16'h0000, 1'b0,1'b0,2'd0,3'd0,3'd0,16'h0000, 1'b0,1'b0,1'b0,1'b0,7'd0,16'h0000,  1'b1,16'h0014,1'b0,16'h0000};
        vecs[4]  = '{1'b0,1'b0,2'd0,3'd0,3'd0,16'h0000, 1'b1,1'b1,2'd2,3'd1,3'd1,16'hFFE2, 1'b0,1'b1,1'b0,1'b0,7'd0,16'h0000,  1'b0,16'h0000,1'b0,16'h0000};
        vecs[5]  = '{1'b1,1'b0,2'd2,3'd1,3'd1,16'h0000, 1'b0,1'b0,2'd0,3'd0,3'd0,16'h0000, 1'b1,1'b0,1'b1,1'b1,7'd56,16'hFFE2, 1'b0,16'h0000,1'b0,16'h0000};
        vecs[6]  = '{1'b0,1'b0,2'd0,3'd0,3'd0,16'h0000, 1'b0,1'b0,2'd0,3'd0,3'd0,16'h0000, 1'b0,1'b0,1'b1,1'b0,7'd56,16'h0000, 1'b0,16'h0000,1'b0,16'h0000};
        vecs[7]  = '{1'b0,1'b0,2'd0,3'd0,3'd0,16'h0000, 1'b0,1'b0,2'd0,3'd0,3'd0,16'h0000, 1'b0,1'b0,1'b0,1'b0,7'd0,16'h0000,  1'b1,16'hFFE2,1'b0,16'h0000};
        vecs[8]  = '{1'b1,1'b0,2'd0,3'd1,3'd2,16'h0000, 1'b1,1'b0,2'd2,3'd1,3'd1,16'h0000, 1'b0,1'b1,1'b0,1'b0,7'd0,16'h0000,  1'b0,16'h0000,1'b0,16'h0000};
        vecs[9]  = '{1'b1,1'b0,2'd0,3'd1,3'd2,16'h0000, 1'b1,1'b0,2'd2,3'd1,3'd1,16'h0000, 1'b1,1'b0,1'b1,1'b0,7'd56,16'h0000, 1'b0,16'h0000,1'b0,16'h0000};
        vecs[10] = '{1'b1,1'b0,2'd0,3'd1,3'd2,16'h0000, 1'b1,1'b0,2'd2,3'd1,3'd1,16'h0000, 1'b0,1'b1,1'b1,1'b0,7'd7,16'h0000,  1'b0,16'h0000,1'b1,16'hFFE2};
        vecs[11] = '{1'b0,1'b0,2'd0,3'd0,3'd0,16'h0000, 1'b0,1'b0,2'd0,3'd0,3'd0,16'h0000, 1'b0,1'b0,1'b1,1'b0,7'd56,16'h0000, 1'b1,16'h0014,1'b0,16'h0000};
        vecs[12] = '{1'b0,1'b0,2'd0,3'd0,3'd0,16'h0000, 1'b0,1'b0,2'd0,3'd0,3'd0,16'h0000, 1'b0,1'b0,1'b0,1'b0,7'd0,16'h0000,  1'b0,16'h0000,1'b1,16'hFFE2};
        vecs[13] = '{1'b1,1'b1,2'd3,3'd4,3'd4,16'h1234, 1'b1,1'b0,2'd1,3'd0,3'd0,16'h0000, 1'b1,1'b0,1'b0,1'b0,7'd0,16'h0000,  1'b0,16'h0000,1'b0,16'h0000};
        vecs[14] = '{1'b0,1'b0,2'd0,3'd0,3'd0,16'h0000, 1'b0,1'b0,2'd0,3'd0,3'd0,16'h0000, 1'b0,1'b0,1'b1,1'b1,7'd99,16'h1234, 1'b0,16'h0000,1'b0,16'h0000};
        vecs[15] = '{1'b0,1'b0,2'd0,3'd0,3'd0,16'h0000, 1'b0,1'b0,2'd0,3'd0,3'd0,16'h0000, 1'b0,1'b0,1'b0,1'b0,7'd0,16'h0000,  1'b0,16'h0000,1'b0,16'h0000};
        vecs[16] = '{1'b0,1'b0,2'd0,3'd0,3'd0,16'h0000, 1'b1,1'b0,2'd3,3'd4,3'd4,16'h0000, 1'b0,1'b1,1'b0,1'b0,7'd0,16'h0000,  1'b0,16'h0000,1'b0,16'h0000};
        vecs[17] = '{1'b0,1'b0,2'd0,3'd0,3'd0,16'h0000, 1'b0,1'b0,2'd0,3'd0,3'd0,16'h0000, 1'b0,1'b0,1'b1,1'b0,7'd99,16'h0000, 1'b0,16'h0000,1'b0,16'h0000};
        vecs[18] = '{1'b0,1'b0,2'd0,3'd0,3'd0,16'h0000, 1'b0,1'b0,2'd0,3'd0,3'd0,16'h0000, 1'b0,1'b0,1'b0,1'b0,7'd0,16'h0000,  1'b0,16'h0000,1'b1,16'h1234};

`ifdef MATRIX_MEM_ARB_BOUNDS_CHECK_EN
        exp_err = 1'b1;
`else
        exp_err = 1'b0;
`endif

        // Reset with both requesters active: every output must read 0.
        drive_idle();
        usr_req   = 1'b1;
        alu_req   = 1'b1;
        sys_rst_n = 1'b0;
        ram_clr   = 1'b1;
        @(negedge sys_clk_in);
        chk_all_zero("reset");
        @(posedge sys_clk_in); #1;
        sys_rst_n = 1'b1;
        ram_clr   = 1'b0;
        drive_idle();

        // Table-driven cycles.
        for (int i = 0; i < NV; i++) begin
            @(posedge sys_clk_in); #1;
            usr_req = vecs[i].ureq; usr_we = vecs[i].uwe; usr_slot = vecs[i].uslot;
            usr_row = vecs[i].urow; usr_col = vecs[i].ucol; usr_wdata = vecs[i].uwd;
            alu_req = vecs[i].areq; alu_we = vecs[i].awe; alu_slot = vecs[i].aslot;
            alu_row = vecs[i].arow; alu_col = vecs[i].acol; alu_wdata = vecs[i].awd;
            @(negedge sys_clk_in);
            chk($sformatf("v%0d usr_gnt", i),      32'(usr_gnt),      32'(vecs[i].e_ugnt));
            chk($sformatf("v%0d alu_gnt", i),      32'(alu_gnt),      32'(vecs[i].e_agnt));
            chk($sformatf("v%0d mem_en", i),       32'(mem_en),       32'(vecs[i].e_men));
            chk($sformatf("v%0d mem_we", i),       32'(mem_we),       32'(vecs[i].e_mwe));
            if (vecs[i].e_men) begin
                chk($sformatf("v%0d mem_addr", i),  32'(mem_addr),  32'(vecs[i].e_maddr));
                chk($sformatf("v%0d mem_wdata", i), 32'(mem_wdata), 32'(vecs[i].e_mwd));
            end
            chk($sformatf("v%0d usr_rd_valid", i), 32'(usr_rd_valid), 32'(vecs[i].e_urv));
            chk($sformatf("v%0d usr_rd_data", i),  32'(usr_rd_data),  32'(vecs[i].e_urd));
            chk($sformatf("v%0d alu_rd_valid", i), 32'(alu_rd_valid), 32'(vecs[i].e_arv));
            chk($sformatf("v%0d alu_rd_data", i),  32'(alu_rd_data),  32'(vecs[i].e_ard));
            chk($sformatf("v%0d arb_err", i),      32'(arb_err),      32'd0);
        end

        // Out-of-range read: row 5, col 0 of slot A.
        @(posedge sys_clk_in); #1;
        drive_idle();
        usr_req = 1'b1;
        usr_row = 3'd5;
        @(negedge sys_clk_in);
        chk("oob usr_gnt", 32'(usr_gnt), 32'd1);
        @(posedge sys_clk_in); #1;
        drive_idle();
        @(negedge sys_clk_in);
`ifdef MATRIX_MEM_ARB_BOUNDS_CHECK_EN
        chk("oob mem_en", 32'(mem_en), 32'd0);
`else
        chk("oob mem_en", 32'(mem_en), 32'd1);
        chk("oob mem_we", 32'(mem_we), 32'd0);
        chk("oob mem_addr", 32'(mem_addr), 32'd25);
`endif
        chk("oob arb_err T+1", 32'(arb_err), 32'(exp_err));
        @(posedge sys_clk_in); #1;
        @(negedge sys_clk_in);
        chk("oob usr_rd_valid", 32'(usr_rd_valid), 32'd1);
        chk("oob usr_rd_data", 32'(usr_rd_data), 32'd0);
        chk("oob alu_rd_valid", 32'(alu_rd_valid), 32'd0);
        chk("oob arb_err T+2", 32'(arb_err), 32'(exp_err));
        for (int k = 0; k < 2; k++) begin
            @(posedge sys_clk_in); #1;
            @(negedge sys_clk_in);
            chk($sformatf("oob sticky %0d arb_err", k), 32'(arb_err), 32'(exp_err));
            chk($sformatf("oob sticky %0d usr_rd_valid", k), 32'(usr_rd_valid), 32'd0);
        end

        // Reset in the cycle after a user read is granted.
        @(posedge sys_clk_in); #1;
        drive_idle();
        usr_req = 1'b1; usr_row = 3'd1; usr_col = 3'd2;
        @(negedge sys_clk_in);
        chk("mid usr_gnt", 32'(usr_gnt), 32'd1);
        @(posedge sys_clk_in); #1;
        sys_rst_n = 1'b0;
        alu_req = 1'b1; alu_slot = 2'd2; alu_row = 3'd1; alu_col = 3'd1;
        @(negedge sys_clk_in);
        chk_all_zero("mid reset a");
        @(posedge sys_clk_in); #1;
        @(negedge sys_clk_in);
        chk_all_zero("mid reset b");
        @(posedge sys_clk_in); #1;
        sys_rst_n = 1'b1;
        usr_req = 1'b0;
        alu_req = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge sys_clk_in);
            chk($sformatf("post rst %0d usr_rd_valid", k), 32'(usr_rd_valid), 32'd0);
            chk($sformatf("post rst %0d alu_rd_valid", k), 32'(alu_rd_valid), 32'd0);
            chk($sformatf("post rst %0d arb_err", k), 32'(arb_err), 32'd0);
            @(posedge sys_clk_in); #1;
        end

        // Both sides read every cycle for 6 cycles: user first, then alternate.
        // User reads addr 7 (0x0014), ALU reads addr 56 (0xFFE2).
        for (int k = 0; k < 9; k++) begin
            usr_req = (k < 6);
            alu_req = (k < 6);
            @(negedge sys_clk_in);
            chk($sformatf("rr %0d usr_gnt", k), 32'(usr_gnt), 32'((k < 6) && (k % 2 == 0)));
            chk($sformatf("rr %0d alu_gnt", k), 32'(alu_gnt), 32'((k < 6) && (k % 2 == 1)));
            chk($sformatf("rr %0d usr_rd_valid", k), 32'(usr_rd_valid),
                32'((k >= 2) && (k < 8) && (k % 2 == 0)));
            chk($sformatf("rr %0d alu_rd_valid", k), 32'(alu_rd_valid),
                32'((k >= 2) && (k < 8) && (k % 2 == 1)));
            chk($sformatf("rr %0d usr_rd_data", k), 32'(usr_rd_data),
                ((k >= 2) && (k < 8) && (k % 2 == 0)) ? 32'h0014 : 32'h0);
            chk($sformatf("rr %0d alu_rd_data", k), 32'(alu_rd_data),
                ((k >= 2) && (k < 8) && (k % 2 == 1)) ? 32'hFFE2 : 32'h0);
            @(posedge sys_clk_in); #1;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
